// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned VEC_W   = 3;
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned GIE_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_ENABLE = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_PEND   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_INSVC  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_RAW    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SVC  = 2'b10
  } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Zero-wait-state register bus between the CPU side and the interrupt controller.
interface int_ctrl_if;
  import int_ctrl_pkg::*;

  logic              i_sel;
  logic              i_we;
  logic              i_re;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rdy;

  modport master (
    output i_sel, i_we, i_re, i_addr, i_wdata,
    input  o_rdata, o_rdy
  );

  modport slave (
    input  i_sel, i_we, i_re, i_addr, i_wdata,
    output o_rdata, o_rdy
  );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req_i,
  output logic [VEC_W-1:0] idx_c_o,
  output logic             valid_c_o
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    idx_c_o   = '0;
    valid_c_o = |req_i;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_c_o = VEC_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller: pending/mask/gie registers, single
// outstanding request to the CPU with ack and EOI handshake.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  int_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] i_irq,
  input  logic             i_cpu_ack,
  output logic             o_cpu_irq,
  output logic [VEC_W-1:0] o_vec
);

  state_e             state_q;
  logic [VEC_W-1:0]   vec_q;
  logic               insvc_q;
  logic               irq_q;
  logic [N_SRC-1:0]   prev_q;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   mask_q;
  logic               gie_q;

  logic               wr_en;
  logic               eoi;
  logic               ack_take;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   w1c;
  logic [N_SRC-1:0]   ack_clr;
  logic [N_SRC-1:0]   eligible;
  logic [MAX_SRC-1:0] elig_pad;
  logic [MAX_SRC-1:0] vec_onehot;
  logic [VEC_W-1:0]   win_idx;
  logic               win_valid;
  logic [DATA_W-1:0]  rdata_c;
  logic               unused_wdata;

  assign wr_en      = bus.i_sel & bus.i_we;
  assign eoi        = wr_en && (bus.i_addr == ADDR_INSVC);
  assign ack_take   = (state_q == ST_REQ) && i_cpu_ack;
  assign rise       = i_irq & ~prev_q;
  assign w1c        = (wr_en && (bus.i_addr == ADDR_PEND)) ? bus.i_wdata[N_SRC-1:0] : '0;
  assign vec_onehot = MAX_SRC'(1) << vec_q;
  assign ack_clr    = ack_take ? vec_onehot[N_SRC-1:0] : '0;
  assign eligible   = pend_q & mask_q & {N_SRC{gie_q}};
  assign elig_pad   = MAX_SRC'(eligible);
  assign unused_wdata = ^bus.i_wdata;

  // Clears apply first so a same-cycle rising edge always survives.
  assign pend_d = (pend_q & ~w1c & ~ack_clr) | rise;

  prio_enc #(.N(N_SRC)) u_prio_enc (
    .req_i     (eligible),
    .idx_c_o   (win_idx),
    .valid_c_o (win_valid)
  );

  // Edge history, pending bits and the enable register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      gie_q  <= 1'b0;
    end else begin
      prev_q <= i_irq;
      pend_q <= pend_d;
      if (wr_en && (bus.i_addr == ADDR_ENABLE)) begin
        mask_q <= bus.i_wdata[N_SRC-1:0];
        gie_q  <= bus.i_wdata[GIE_BIT];
      end
    end
  end

  // Request/ack/EOI handshake; ack beats a same-cycle withdrawal.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      insvc_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            vec_q   <= win_idx;
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_cpu_ack) begin
            state_q <= ST_SVC;
            insvc_q <= 1'b1;
            irq_q   <= 1'b0;
          end else if (!elig_pad[vec_q]) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        ST_SVC: begin
          if (eoi) begin
            state_q <= ST_IDLE;
            insvc_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  // Register readback, zero unless selected and reading.
  always_comb begin
    rdata_c = '0;
    if (bus.i_sel && bus.i_re) begin
      case (bus.i_addr)
        ADDR_ENABLE: begin
          rdata_c          = DATA_W'(mask_q);
          rdata_c[GIE_BIT] = gie_q;
        end
        ADDR_PEND:  rdata_c = DATA_W'(pend_q);
        ADDR_INSVC: rdata_c = {6'b0, state_q, insvc_q, 4'b0, vec_q};
        ADDR_RAW:   rdata_c = DATA_W'(i_irq);
        default:    rdata_c = '0;
      endcase
    end
  end

  assign bus.o_rdata = rdata_c;
  assign bus.o_rdy   = bus.i_sel;
  assign o_cpu_irq   = irq_q;
  assign o_vec       = vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (N_SRC = 4).
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_irq;
  logic       i_cpu_ack;
  logic       o_cpu_irq;
  logic [2:0] o_vec;
  int         checks;
  int         failures;

  int_ctrl_if bus ();

  int_ctrl #(.N_SRC(4)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus),
    .i_irq     (i_irq),
    .i_cpu_ack (i_cpu_ack),
    .o_cpu_irq (o_cpu_irq),
    .o_vec     (o_vec)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus.i_sel   = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_re    = 1'b0;
    bus.i_addr  = a;
    bus.i_wdata = d;
    step();
    bus.i_sel   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    bus.i_sel  = 1'b1;
    bus.i_re   = 1'b1;
    bus.i_we   = 1'b0;
    bus.i_addr = a;
    #1;
    d = bus.o_rdata;
    bus.i_sel  = 1'b0;
    bus.i_re   = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    i_rst_n = 1'b0;
    i_irq = '0;
    i_cpu_ack = 1'b0;
    bus.i_sel = 1'b0; bus.i_we = 1'b0; bus.i_re = 1'b0;
    bus.i_addr = '0; bus.i_wdata = '0;
    #12;
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", o_cpu_irq); end
    checks++;
    if (o_vec !== 3'd0) begin failures++; $display("FAIL reset_vec got=%0d exp=0", o_vec); end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0000", a, d); end
    end
    bus.i_sel = 1'b1; bus.i_re = 1'b0; bus.i_addr = ADDR_ENABLE;
    #1;
    checks++;
    if (bus.o_rdy !== 1'b1 || bus.o_rdata !== 16'h0000) begin
      failures++; $display("FAIL sel_no_re got rdy=%b rdata=%h exp rdy=1 rdata=0000", bus.o_rdy, bus.o_rdata);
    end
    bus.i_sel = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] d;
    bus_write(ADDR_ENABLE, 16'h8003);
    i_irq[1] = 1'b1;
    step();
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b exp=0", o_cpu_irq); end
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd1) begin
      failures++; $display("FAIL basic_req got irq=%b vec=%0d exp irq=1 vec=1", o_cpu_irq, o_vec);
    end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0002) begin failures++; $display("FAIL basic_pend got=%h exp=0002", d); end
    bus_write(ADDR_INSVC, 16'h0000);
    checks++;
    if (o_cpu_irq !== 1'b1) begin failures++; $display("FAIL eoi_in_req got irq=%b exp=1", o_cpu_irq); end
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL basic_ack_irq got=%b exp=0", o_cpu_irq); end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL basic_ack_pend got=%h exp=0000", d); end
    bus_read(ADDR_INSVC, d);
    checks++;
    if (d !== 16'h0281) begin failures++; $display("FAIL basic_svc got=%h exp=0281", d); end
    bus_write(ADDR_INSVC, 16'h0000);
    bus_read(ADDR_INSVC, d);
    checks++;
    if (d !== 16'h0001) begin failures++; $display("FAIL basic_eoi got=%h exp=0001", d); end
    i_irq[1] = 1'b0;
    step();
  endtask

  task automatic test_priority();
    logic [15:0] d;
    bus_write(ADDR_ENABLE, 16'h800F);
    i_irq = 4'b1001;
    step();
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd0) begin
      failures++; $display("FAIL prio_first got irq=%b vec=%0d exp irq=1 vec=0", o_cpu_irq, o_vec);
    end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0009) begin failures++; $display("FAIL prio_pend got=%h exp=0009", d); end
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0008) begin failures++; $display("FAIL prio_ack_pend got=%h exp=0008", d); end
    bus_write(ADDR_INSVC, 16'h0000);
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL prio_eoi_idle got irq=%b exp=0", o_cpu_irq); end
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd3) begin
      failures++; $display("FAIL prio_second got irq=%b vec=%0d exp irq=1 vec=3", o_cpu_irq, o_vec);
    end
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    bus_write(ADDR_INSVC, 16'h0000);
    i_irq = '0;
    step();
  endtask

  task automatic test_withdraw();
    logic [15:0] d;
    i_irq[2] = 1'b1;
    step();
    i_irq[2] = 1'b0;
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd2) begin
      failures++; $display("FAIL wd_req got irq=%b vec=%0d exp irq=1 vec=2", o_cpu_irq, o_vec);
    end
    bus_write(ADDR_ENABLE, 16'h8000);
    step();
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL wd_drop got irq=%b exp=0", o_cpu_irq); end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0004) begin failures++; $display("FAIL wd_pend got=%h exp=0004", d); end
    bus_write(ADDR_ENABLE, 16'h8004);
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd2) begin
      failures++; $display("FAIL wd_rereq got irq=%b vec=%0d exp irq=1 vec=2", o_cpu_irq, o_vec);
    end
    bus_write(ADDR_ENABLE, 16'h8000);
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    bus_read(ADDR_INSVC, d);
    checks++;
    if (d !== 16'h0282) begin failures++; $display("FAIL ack_vs_wd got=%h exp=0282", d); end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL ack_vs_wd_pend got=%h exp=0000", d); end
    bus_write(ADDR_INSVC, 16'h0000);
  endtask

  task automatic test_collision();
    logic [15:0] d;
    i_irq[1] = 1'b1;
    bus_write(ADDR_PEND, 16'h0002);
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0002) begin failures++; $display("FAIL set_vs_w1c got=%h exp=0002", d); end
    bus_write(ADDR_PEND, 16'h0002);
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL w1c got=%h exp=0000", d); end
    i_irq[1] = 1'b0;
    step();
  endtask

  task automatic test_level_hold();
    logic [15:0] d;
    int n_req;
    bus_write(ADDR_ENABLE, 16'h8001);
    i_irq[0] = 1'b1;
    n_req = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_cpu_irq === 1'b1) begin
        n_req++;
        i_cpu_ack = 1'b1;
      end else begin
        i_cpu_ack = 1'b0;
      end
      step();
    end
    i_cpu_ack = 1'b0;
    checks++;
    if (n_req !== 1) begin failures++; $display("FAIL level_once got=%0d exp=1", n_req); end
    bus_read(ADDR_INSVC, d);
    checks++;
    if (d !== 16'h0280) begin failures++; $display("FAIL level_svc got=%h exp=0280", d); end
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL level_pend got=%h exp=0000", d); end
    bus_write(ADDR_INSVC, 16'h0000);
    step();
    step();
    checks++;
    if (o_cpu_irq !== 1'b0) begin failures++; $display("FAIL level_no_rereq got=%b exp=0", o_cpu_irq); end
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    bus_read(ADDR_INSVC, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL ack_in_idle got=%h exp=0000", d); end
    i_irq[0] = 1'b0;
    step();
    i_irq[0] = 1'b1;
    step();
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd0) begin
      failures++; $display("FAIL level_second got irq=%b vec=%0d exp irq=1 vec=0", o_cpu_irq, o_vec);
    end
    i_cpu_ack = 1'b1;
    step();
    i_cpu_ack = 1'b0;
    bus_write(ADDR_INSVC, 16'h0000);
    i_irq[0] = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    bus_write(ADDR_ENABLE, 16'h8002);
    i_irq[1] = 1'b1;
    step();
    step();
    checks++;
    if (o_cpu_irq !== 1'b1 || o_vec !== 3'd1) begin
      failures++; $display("FAIL ar_req got irq=%b vec=%0d exp irq=1 vec=1", o_cpu_irq, o_vec);
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_cpu_irq !== 1'b0 || o_vec !== 3'd0) begin
      failures++; $display("FAIL ar_abort got irq=%b vec=%0d exp irq=0 vec=0", o_cpu_irq, o_vec);
    end
    i_irq[1] = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 16'h0000) begin failures++; $display("FAIL ar_reg%0d got=%h exp=0000", a, d); end
    end
    step();
    i_rst_n = 1'b0;
    i_irq[2] = 1'b1;
    step();
    i_rst_n = 1'b1;
    step();
    bus_read(ADDR_PEND, d);
    checks++;
    if (d !== 16'h0004) begin failures++; $display("FAIL ar_high_at_release got=%h exp=0004", d); end
    bus_read(ADDR_RAW, d);
    checks++;
    if (d !== 16'h0004) begin failures++; $display("FAIL raw_read got=%h exp=0004", d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_collision();
    test_level_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources, legal range 1..8.
REQ-002 The reset style SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_sel  input  1  bus select for this block.
REQ-006 i_we  input  1  bus write strobe.
REQ-007 i_re  input  1  bus read strobe.
REQ-008 i_addr  input  2  register address.
REQ-009 i_wdata  input  16  write data.
REQ-010 o_rdata  output  16  read data; 0 when !i_sel or !i_re.
REQ-011 o_rdy  output  1  equals i_sel, so bus access completes in zero wait states.
REQ-012 i_irq  input  N_SRC  level requests from peripherals, e.g. the timers' o_int_req; bit 0 has the highest priority.
REQ-013 o_cpu_irq  output  1  interrupt request to the CPU.
REQ-014 o_vec  output  3  index of the requesting or in-service source.
REQ-015 i_cpu_ack  input  1  single-cycle CPU acknowledge.

Function
REQ-016 Edge detection: a per-source register holds the previous i_irq value; a rising edge (i_irq=1, previous=0) sets pend[k].
REQ-017 Address 00, enable register: bits [N_SRC-1:0] form the mask, bit 15 is gie; the register is read/write.
REQ-018 Address 01, pending register: read returns pend; a write clears each pend bit whose i_wdata bit is 1 (write-1-to-clear).
REQ-019 If a set and a write-1-to-clear hit the same pend bit in the same cycle, the set SHALL win.
REQ-020 Address 10, in-service register: read returns {state[1:0] at bits 9:8, insvc at bit 7, vec at bits 2:0}; any write is an EOI.
REQ-021 Address 11, raw register: reads i_irq (zero-extended); writes are ignored.
REQ-022 eligible = pend & mask & {N_SRC{gie}}; the winner is the lowest set index of eligible.
REQ-023 The FSM SHALL have the states IDLE, REQ and SVC, with state codes 00, 01 and 10.
REQ-024 IDLE: if eligible != 0, the winner index SHALL be latched into vec and the FSM SHALL go to REQ; o_cpu_irq asserts in the following cycle (1-cycle latency from pend to o_cpu_irq).
REQ-025 REQ: o_cpu_irq=1 and vec is held stable.
REQ-026 REQ with i_cpu_ack=1: the FSM SHALL clear pend[vec], set insvc, and go to SVC; o_cpu_irq falls in the following cycle.
REQ-027 REQ with eligible[vec]=0 (masked, cleared, or gie cleared) and no ack: the request SHALL be withdrawn and the FSM SHALL return to IDLE with no pend change.
REQ-028 REQ when ack and withdrawal occur in the same cycle: the ack SHALL win.
REQ-029 SVC: o_cpu_irq=0; new pend bits still accumulate; no nesting.
REQ-030 SVC on an EOI write: the FSM SHALL clear insvc and go to IDLE; rearbitration happens in the next cycle.
REQ-031 i_cpu_ack in IDLE or SVC SHALL be ignored.
REQ-032 An EOI in IDLE or REQ SHALL be ignored.
REQ-033 A source held high SHALL produce only one pend set until it falls and rises again.
REQ-034 A higher-priority edge arriving during REQ SHALL NOT change vec; it is served after EOI.

Reset
REQ-035 While i_rst_n=0: state=IDLE, pend=0, mask=0, gie=0, insvc=0, vec=0, previous i_irq=0, o_cpu_irq=0, o_vec=0.
REQ-036 A source already high when reset deasserts SHALL register an edge on the first clock after reset.
REQ-037 Reset asserted mid-handshake SHALL abort immediately to IDLE with no pending retained.

Structure
REQ-038 A shared package SHALL hold the state encodings (IDLE/REQ/SVC), the register address constants (ENABLE=00, PEND=01, INSVC=10, RAW=11) and GIE_BIT=15.
REQ-039 One sub-module, prio_enc (N_SRC-bit lowest-index priority encoder with a valid flag), SHALL provide the winner index; all other logic resides in int_ctrl.

Verification
REQ-040 Basic flow: mask=0x0003, gie=1, i_irq[1] rises -> o_cpu_irq=1 with o_vec=1 two cycles later; ack -> pend=0, state=SVC; EOI -> IDLE.
REQ-041 Priority: i_irq[3] and i_irq[0] rise in the same cycle with mask=0xF -> o_vec=0 first; after ack and EOI -> o_vec=3.
REQ-042 Withdrawal: in REQ with vec=2, write mask=0x0 -> o_cpu_irq drops within one cycle, pend[2] stays 1; re-enabling the mask re-requests vec=2.
REQ-043 Collision: a write-1-to-clear to pend bit 1 in the same cycle as a rising edge on i_irq[1] -> pend[1]=1; ack in the same cycle as withdrawal -> SVC entered.
REQ-044 Level hold: i_irq[0] held high for 50 cycles -> exactly one pend set and one ack; a new pulse after EOI -> a second request.
REQ-045 Async reset: assert i_rst_n=0 mid-cycle during REQ -> o_cpu_irq=0 without waiting for a clock; all readback registers read 0x0000 after release.
